// File: rtl/uart_pkg.sv
// Shared constants for the parametrised UART transmitter: parity modes,
// FSM state encoding and the baud divider helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  // Clock cycles per bit, rounded to nearest.
  function automatic int unsigned baud_ticks(input int unsigned clk_freq,
                                             input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO buffering words ahead of the UART shifter.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_wr) - LW'(do_rd);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (5..9 data bits, none/odd/even parity, 1/2 stop).
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-word input FIFO instead of one holding register.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned BAUD_TICKS = baud_ticks(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W      = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;
  localparam int unsigned IDX_W      = $clog2(DATA_BITS + 1);
  localparam int unsigned LEVEL_W    = $clog2(FIFO_DEPTH) + 1;

  if (BAUD_TICKS < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_cfg
    $error("uart_tx_param: illegal parameter combination");
  end

  logic                 push;
  logic                 pop;
  logic                 buf_empty;
  logic [DATA_BITS-1:0] buf_data;
  logic [LEVEL_W-1:0]   buf_level;
  logic [LEVEL_W-1:0]   level_nxt;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned CAPACITY = FIFO_DEPTH;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  logic fifo_full;

  assign push = s_valid & s_ready & ~fifo_full;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (s_data),
    .rd_en   (pop),
    .rd_data (buf_data),
    .full    (fifo_full),
    .empty   (buf_empty),
    .level   (buf_level)
  );
`else
  localparam int unsigned CAPACITY = 1;

  logic                 hold_valid;
  logic [DATA_BITS-1:0] hold_data;

  assign push      = s_valid & s_ready;
  assign buf_empty = ~hold_valid;
  assign buf_data  = hold_data;
  assign buf_level = LEVEL_W'(hold_valid);

  // Single-entry holding register; s_ready keeps it from being overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_data  <= s_data;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  assign level     = buf_level;
  assign level_nxt = buf_level + LEVEL_W'(push) - LEVEL_W'(pop);

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tick;
  logic                 tx_d;
  logic                 busy_d;
  logic                 s_ready_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      s_ready <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx      <= tx_d;
      busy    <= busy_d;
      s_ready <= s_ready_d;
    end
  end

  // Next state; tx is derived from the next state so the line changes on the pop edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop       = 1'b0;
    tx_d      = 1'b1;
    tick      = (cnt_q == CNT_W'(BAUD_TICKS - 1));

    if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE:  pop = ~buf_empty;
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? PAR : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PAR:   if (tick) state_d = STOP;
      STOP: begin
        // idx doubles as the stop-bit counter.
        if (tick) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
            pop     = ~buf_empty;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      state_d = START;
      cnt_d   = '0;
      idx_d   = '0;
      shift_d = buf_data;
      par_d   = (PARITY == PAR_ODD) ? ~^buf_data : ^buf_data;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PAR:     tx_d = par_d;
      default: tx_d = 1'b1;
    endcase

    busy_d    = (state_d != IDLE) | (level_nxt != '0);
    s_ready_d = (level_nxt < LEVEL_W'(CAPACITY));
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param at 10 clocks per bit.
module tb_uart_tx_param;

`ifdef UART_TX_FIFO_EN
  localparam int EXP_CAP = 4;
`else
  localparam int EXP_CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] d_n1, d_par;
  logic [6:0] d_7;

  logic       rdy_n1, tx_n1, busy_n1;
  logic       rdy_e1, tx_e1, busy_e1;
  logic       rdy_o1, tx_o1, busy_o1;
  logic       rdy_7,  tx_7,  busy_7;
  logic [2:0] lvl_n1, lvl_e1, lvl_o1, lvl_7;

  logic [9:0]  f_a5, f_3c, f_c3, f_7f;
  logic [10:0] f_e1, f_o1;

  int tests = 0;
  int fails = 0;
  int acc;
  int n;

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n1 (
    .clk(clk), .rst(rst), .s_data(d_n1), .s_valid(s_valid), .s_ready(rdy_n1),
    .tx(tx_n1), .busy(busy_n1), .level(lvl_n1));

  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e1 (
    .clk(clk), .rst(rst), .s_data(d_par), .s_valid(s_valid), .s_ready(rdy_e1),
    .tx(tx_e1), .busy(busy_e1), .level(lvl_e1));

  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o1 (
    .clk(clk), .rst(rst), .s_data(d_par), .s_valid(s_valid), .s_ready(rdy_o1),
    .tx(tx_o1), .busy(busy_o1), .level(lvl_o1));

  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                  .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7 (
    .clk(clk), .rst(rst), .s_data(d_7), .s_valid(s_valid), .s_ready(rdy_7),
    .tx(tx_7), .busy(busy_7), .level(lvl_7));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Samples the ten bit centres of an 8N1 frame on u_n1.
  task automatic bits_n1(input logic [9:0] exp, input string tag, input int first_wait);
    adv(first_wait);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) adv(10);
      check($sformatf("%s bit%0d", tag, k), 32'(tx_n1), 32'(exp >> k) & 1);
    end
  endtask

  initial begin
    f_a5 = 10'b1101001010;
    f_3c = 10'b1001111000;
    f_c3 = 10'b1110000110;
    f_7f = 10'b1111111110;
    f_e1 = 11'b10000000110;
    f_o1 = 11'b11000000110;
    rst = 1'b1; s_valid = 1'b0; d_n1 = '0; d_par = '0; d_7 = '0;

    adv(3);
    check("rst tx",      32'(tx_n1),   1);
    check("rst busy",    32'(busy_n1), 0);
    check("rst s_ready", 32'(rdy_n1),  1);
    check("rst level",   32'(lvl_n1),  0);
    check("rst tx_7",    32'(tx_7),    1);
    rst = 1'b0;
    adv(2);
    check("idle tx",   32'(tx_n1),   1);
    check("idle busy", 32'(busy_n1), 0);

    // One frame on each configuration in parallel.
    d_n1 = 8'hA5; d_par = 8'h03; d_7 = 7'h7F; s_valid = 1'b1;
    adv(1);
    s_valid = 1'b0;
    check("accept tx",      32'(tx_n1),   1);
    check("accept busy",    32'(busy_n1), 1);
    check("accept level",   32'(lvl_n1),  1);
    check("accept s_ready", 32'(rdy_n1),  (EXP_CAP > 1) ? 1 : 0);
    adv(1);
    check("pop tx_n1", 32'(tx_n1), 0);
    check("pop tx_e1", 32'(tx_e1), 0);
    check("pop tx_7",  32'(tx_7),  0);
    adv(5);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) adv(10);
      check($sformatf("8n1 bit%0d", k), 32'(tx_n1), 32'(f_a5 >> k) & 1);
      check($sformatf("8e1 bit%0d", k), 32'(tx_e1), 32'(f_e1 >> k) & 1);
      check($sformatf("8o1 bit%0d", k), 32'(tx_o1), 32'(f_o1 >> k) & 1);
      check($sformatf("7n2 bit%0d", k), 32'(tx_7),  32'(f_7f >> k) & 1);
    end
    adv(4);
    check("8n1 busy end-1", 32'(busy_n1), 1);
    check("7n2 busy end-1", 32'(busy_7),  1);
    adv(1);
    check("8n1 busy end", 32'(busy_n1), 0);
    check("8n1 tx end",   32'(tx_n1),   1);
    check("7n2 busy end", 32'(busy_7),  0);
    check("8e1 busy mid", 32'(busy_e1), 1);
    adv(5);
    check("8e1 bit10", 32'(tx_e1), 32'(f_e1 >> 10) & 1);
    check("8o1 bit10", 32'(tx_o1), 32'(f_o1 >> 10) & 1);
    adv(4);
    check("8e1 busy end-1", 32'(busy_e1), 1);
    adv(1);
    check("8e1 busy end", 32'(busy_e1), 0);
    check("8o1 busy end", 32'(busy_o1), 0);

    // Back-to-back frames: second word buffered while the first is in flight.
    d_n1 = 8'h3C; s_valid = 1'b1;
    adv(1);
    s_valid = 1'b0;
    adv(1);
    d_n1 = 8'hC3; s_valid = 1'b1;
    adv(1);
    s_valid = 1'b0;
    check("b2b s_ready", 32'(rdy_n1), (EXP_CAP > 1) ? 1 : 0);
    check("b2b level",   32'(lvl_n1), 1);
    bits_n1(f_3c, "b2b f1", 4);
    adv(4);
    check("b2b tx end-1",   32'(tx_n1),   1);
    check("b2b busy end-1", 32'(busy_n1), 1);
    adv(1);
    check("b2b gap tx",      32'(tx_n1),   0);
    check("b2b gap busy",    32'(busy_n1), 1);
    check("b2b gap s_ready", 32'(rdy_n1),  1);
    check("b2b gap level",   32'(lvl_n1),  0);
    bits_n1(f_c3, "b2b f2", 5);
    adv(5);
    check("b2b busy end", 32'(busy_n1), 0);
    check("b2b tx end",   32'(tx_n1),   1);

    // Fill the buffer with s_valid held high.
    d_n1 = 8'h50; s_valid = 1'b1; acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (rdy_n1) acc++;
      adv(1);
    end
    check("fill accepts", 32'(acc),     32'(1 + EXP_CAP));
    check("fill level",   32'(lvl_n1),  32'(EXP_CAP));
    check("fill s_ready", 32'(rdy_n1),  0);
    check("fill busy",    32'(busy_n1), 1);
    n = 0;
    while (!rdy_n1 && n < 200) begin
      adv(1);
      n++;
    end
    check("fill ready wait", 32'(n),      90);
    check("fill pop level",  32'(lvl_n1), 32'(EXP_CAP - 1));
    check("fill pop tx",     32'(tx_n1),  0);
    s_valid = 1'b0;

    // Asynchronous reset 35 cycles into a frame.
    adv(35);
    check("pre-rst tx", 32'(tx_n1), 0);
    rst = 1'b1;
    #1;
    check("mid-rst tx",      32'(tx_n1),   1);
    check("mid-rst busy",    32'(busy_n1), 0);
    check("mid-rst level",   32'(lvl_n1),  0);
    check("mid-rst s_ready", 32'(rdy_n1),  1);
    adv(1);
    rst = 1'b0;
    adv(2);
    check("post-rst busy", 32'(busy_n1), 0);
    check("post-rst tx",   32'(tx_n1),   1);
    d_n1 = 8'hA5; s_valid = 1'b1;
    adv(1);
    s_valid = 1'b0;
    adv(1);
    check("post-rst start", 32'(tx_n1), 0);
    bits_n1(f_a5, "post-rst", 5);
    adv(4);
    check("post-rst busy end-1", 32'(busy_n1), 1);
    adv(1);
    check("post-rst busy end", 32'(busy_n1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
